// File: rtl/mul_accum_pkg.sv
// mul_accum_pkg: shared constants and state encodings for the product accumulator.
//   DW_DEF/ACCW_DEF/LEN_DEF : default product width, sum width, products per sum
//   CNTW                    : width of the product counter (LEN up to 256)
//   acc_state_t             : EMPTY / ACCUM accumulator states
//   out_state_t             : OUT_IDLE / OUT_FULL output-register states
package mul_accum_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned ACCW_DEF = 40;
  localparam int unsigned LEN_DEF  = 16;
  localparam int unsigned CNTW     = 8;

  typedef logic [0:0] acc_state_t;
  localparam acc_state_t EMPTY = 1'b0;
  localparam acc_state_t ACCUM = 1'b1;

  typedef logic [0:0] out_state_t;
  localparam out_state_t OUT_IDLE = 1'b0;
  localparam out_state_t OUT_FULL = 1'b1;

endpackage

// File: rtl/mul_accum_if.sv
// mul_accum_if: product input stream, clear, and finished-sum handshake.
//   vldin/din/clear : product stream from the multiplier plus restart
//   vldout/rdyout   : valid/ready handshake for the finished sum
//   dout/sat/drop   : finished sum, clamp flag, sticky lost-sum flag
//   cnt             : products in the current partial sum
// master = producer/consumer side (testbench), slave = mul_accum.
interface mul_accum_if
  import mul_accum_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned ACCW = ACCW_DEF
);
  logic            vldin;
  logic [DW-1:0]   din;
  logic            clear;
  logic            vldout;
  logic            rdyout;
  logic [ACCW-1:0] dout;
  logic            sat;
  logic            drop;
  logic [CNTW-1:0] cnt;

  modport master (
    output vldin, din, clear, rdyout,
    input  vldout, dout, sat, drop, cnt
  );

  modport slave (
    input  vldin, din, clear, rdyout,
    output vldout, dout, sat, drop, cnt
  );
endinterface

// File: rtl/mul_accum_hold.sv
// mul_accum_hold: output register for finished sums with valid/ready handshake.
//   load/sum/sat_in : a completed sum (and its clamp flag) this cycle
//   rdyout          : downstream accepts dout this cycle
//   vldout/dout/sat : held finished sum
//   drop            : sticky, set when a sum arrives while the held one is refused
module mul_accum_hold
  import mul_accum_pkg::*;
#(
  parameter int unsigned ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [ACCW-1:0] sum,
  input  logic            sat_in,
  input  logic            rdyout,
  output logic            vldout,
  output logic [ACCW-1:0] dout,
  output logic            sat,
  output logic            drop
);

  out_state_t      st_q, st_d;
  logic [ACCW-1:0] dout_q, dout_d;
  logic            sat_q, sat_d;
  logic            drop_q, drop_d;

  // Next-state: load when empty or when the held sum leaves this cycle.
  always_comb begin
    st_d   = st_q;
    dout_d = dout_q;
    sat_d  = sat_q;
    drop_d = drop_q;
    case (st_q)
      OUT_IDLE: begin
        if (load) begin
          st_d   = OUT_FULL;
          dout_d = sum;
          sat_d  = sat_in;
        end
      end
      OUT_FULL: begin
        if (rdyout) begin
          if (load) begin
            dout_d = sum;
            sat_d  = sat_in;
          end else begin
            st_d = OUT_IDLE;
          end
        end else if (load) begin
          drop_d = 1'b1;
        end
      end
      default: st_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= OUT_IDLE;
      dout_q <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  assign vldout = (st_q == OUT_FULL);
  assign dout   = dout_q;
  assign sat    = sat_q;
  assign drop   = drop_q;

endmodule

// File: rtl/mul_accum.sv
// mul_accum: sums every LEN consecutive products into one unsigned ACCW-bit result.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mul_accum_if.slave (product stream, clear, sum handshake, cnt)
// Build option: define MUL_ACCUM_SAT_EN to clamp sums at 2^ACCW-1 and report sat;
// otherwise sums wrap and sat stays 0.
module mul_accum
  import mul_accum_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned ACCW = ACCW_DEF,
  parameter int unsigned LEN  = LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_accum_if.slave bus
);

  localparam logic [CNTW-1:0] LAST = CNTW'(LEN - 1);

  logic [ACCW-1:0] acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  acc_state_t      acc_st_c;
  logic [DW-1:0]   din_w;
  logic            start_c;
  logic [ACCW-1:0] base_c;
  logic [CNTW-1:0] cnt_base_c;
  logic [ACCW-1:0] sum_c;
  logic            sat_c;
  logic            done_c;

  assign din_w    = bus.din;
  assign acc_st_c = (cnt_q == '0) ? EMPTY : ACCUM;

  // A product starts a fresh sum when empty or when clear coincides with it.
  assign start_c    = bus.clear || (acc_st_c == EMPTY);
  assign base_c     = start_c ? '0 : acc_q;
  assign cnt_base_c = start_c ? '0 : cnt_q;
  assign done_c     = bus.vldin && (cnt_base_c == LAST);

`ifdef MUL_ACCUM_SAT_EN
  logic          sacc_q, sacc_d;
  logic [ACCW:0] wide_c;

  // Clamp on carry-out; a clamped sum stays clamped until it completes.
  always_comb begin
    wide_c = {1'b0, base_c} + {1'b0, ACCW'(din_w)};
    sat_c  = wide_c[ACCW] | (!start_c & sacc_q);
    sum_c  = sat_c ? '1 : wide_c[ACCW-1:0];
  end
`else
  assign sum_c = base_c + ACCW'(din_w);
  assign sat_c = 1'b0;
`endif

  // Accumulator and counter next state.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
`ifdef MUL_ACCUM_SAT_EN
    sacc_d = sacc_q;
`endif
    if (bus.vldin) begin
      if (done_c) begin
        acc_d = '0;
        cnt_d = '0;
`ifdef MUL_ACCUM_SAT_EN
        sacc_d = 1'b0;
`endif
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_base_c + CNTW'(1);
`ifdef MUL_ACCUM_SAT_EN
        sacc_d = sat_c;
`endif
      end
    end else if (bus.clear) begin
      acc_d = '0;
      cnt_d = '0;
`ifdef MUL_ACCUM_SAT_EN
      sacc_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
`ifdef MUL_ACCUM_SAT_EN
      sacc_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`ifdef MUL_ACCUM_SAT_EN
      sacc_q <= sacc_d;
`endif
    end
  end

  assign bus.cnt = cnt_q;

  mul_accum_hold #(
    .ACCW (ACCW)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (done_c),
    .sum    (sum_c),
    .sat_in (sat_c),
    .rdyout (bus.rdyout),
    .vldout (bus.vldout),
    .dout   (bus.dout),
    .sat    (bus.sat),
    .drop   (bus.drop)
  );

endmodule

// File: tb/tb_mul_accum.sv
// tb_mul_accum: directed checks of mul_accum across several LEN/ACCW configurations.
module tb_mul_accum;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MUL_ACCUM_SAT_EN
  localparam logic [63:0] EXP36     = 64'h0000_000F_FFFF_FFFF;
  localparam logic [63:0] EXP36_SAT = 64'd1;
`else
  localparam logic [63:0] EXP36     = 64'h0000_000F_FFFF_FFE0;
  localparam logic [63:0] EXP36_SAT = 64'd0;
`endif

  mul_accum_if #(.DW(32), .ACCW(40)) i4   ();
  mul_accum_if #(.DW(32), .ACCW(40)) i256 ();
  mul_accum_if #(.DW(32), .ACCW(36)) i36  ();
  mul_accum_if #(.DW(32), .ACCW(40)) i2   ();
  mul_accum_if #(.DW(32), .ACCW(40)) i1   ();

  mul_accum #(.DW(32), .ACCW(40), .LEN(4))   u4   (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  mul_accum #(.DW(32), .ACCW(40), .LEN(256)) u256 (.clk(clk), .rst_n(rst_n), .bus(i256.slave));
  mul_accum #(.DW(32), .ACCW(36), .LEN(32))  u36  (.clk(clk), .rst_n(rst_n), .bus(i36.slave));
  mul_accum #(.DW(32), .ACCW(40), .LEN(2))   u2   (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  mul_accum #(.DW(32), .ACCW(40), .LEN(1))   u1   (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i4.vldin = 0;   i4.din = '0;   i4.clear = 0;   i4.rdyout = 0;
    i256.vldin = 0; i256.din = '0; i256.clear = 0; i256.rdyout = 0;
    i36.vldin = 0;  i36.din = '0;  i36.clear = 0;  i36.rdyout = 0;
    i2.vldin = 0;   i2.din = '0;   i2.clear = 0;   i2.rdyout = 0;
    i1.vldin = 0;   i1.din = '0;   i1.clear = 0;   i1.rdyout = 0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_vldout", 64'(i4.vldout), 64'd0);
    check("rst_dout",   64'(i4.dout),   64'd0);
    check("rst_cnt",    64'(i4.cnt),    64'd0);
    check("rst_drop",   64'(i4.drop),   64'd0);
    check("rst_sat",    64'(i36.sat),   64'd0);

    // LEN=4: 100+200+300+400
    i4.rdyout = 1;
    i4.vldin = 1;
    i4.din = 32'd100; step(); check("l4_cnt1", 64'(i4.cnt), 64'd1);
    i4.din = 32'd200; step(); check("l4_cnt2", 64'(i4.cnt), 64'd2);
    i4.din = 32'd300; step(); check("l4_cnt3", 64'(i4.cnt), 64'd3);
    check("l4_novld", 64'(i4.vldout), 64'd0);
    i4.din = 32'd400; step();
    check("l4_vld",  64'(i4.vldout), 64'd1);
    check("l4_dout", 64'(i4.dout),   64'd1000);
    check("l4_cnt0", 64'(i4.cnt),    64'd0);
    i4.vldin = 0;
    step();
    check("l4_vld_1cyc", 64'(i4.vldout), 64'd0);

    // LEN=256 of 0xFFFFFFFF, 40-bit sum
    i256.rdyout = 1;
    i256.vldin = 1;
    i256.din = 32'hFFFF_FFFF;
    for (int k = 0; k < 255; k++) step();
    check("l256_cnt255", 64'(i256.cnt),    64'd255);
    check("l256_novld",  64'(i256.vldout), 64'd0);
    step();
    check("l256_vld",  64'(i256.vldout), 64'd1);
    check("l256_dout", 64'(i256.dout),   64'h0000_00FF_FFFF_FF00);
    check("l256_sat",  64'(i256.sat),    64'd0);
    check("l256_cnt0", 64'(i256.cnt),    64'd0);
    i256.vldin = 0;
    step();
    check("l256_done", 64'(i256.vldout), 64'd0);

    // ACCW=36, LEN=32 of 0xFFFFFFFF: clamps or wraps depending on build
    i36.rdyout = 1;
    i36.vldin = 1;
    i36.din = 32'hFFFF_FFFF;
    for (int k = 0; k < 32; k++) step();
    check("a36_vld",  64'(i36.vldout), 64'd1);
    check("a36_dout", 64'(i36.dout),   EXP36);
    check("a36_sat",  64'(i36.sat),    EXP36_SAT);
    i36.vldin = 0;
    step();

    // LEN=2, refused output: 1+2 held, 3+4 dropped
    i2.rdyout = 0;
    i2.vldin = 1;
    i2.din = 32'd1; step();
    i2.din = 32'd2; step();
    check("l2_vld_a",  64'(i2.vldout), 64'd1);
    check("l2_dout_a", 64'(i2.dout),   64'd3);
    i2.din = 32'd3; step();
    i2.din = 32'd4; step();
    check("l2_hold_dout", 64'(i2.dout),   64'd3);
    check("l2_hold_vld",  64'(i2.vldout), 64'd1);
    check("l2_drop",      64'(i2.drop),   64'd1);
    i2.vldin = 0;
    i2.rdyout = 1;
    step();
    check("l2_acc_vld",  64'(i2.vldout), 64'd0);
    check("l2_drop_stk", 64'(i2.drop),   64'd1);

    // Reset clears drop; then accept and reload on the same edge
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("l2_drop_rst", 64'(i2.drop), 64'd0);
    i2.rdyout = 0;
    i2.vldin = 1;
    i2.din = 32'd5; step();
    i2.din = 32'd6; step();
    check("l2_b_dout", 64'(i2.dout), 64'd11);
    i2.din = 32'd7; step();
    check("l2_b_stable", 64'(i2.dout), 64'd11);
    i2.din = 32'd8;
    i2.rdyout = 1;
    step();
    check("l2_reload_vld",  64'(i2.vldout), 64'd1);
    check("l2_reload_dout", 64'(i2.dout),   64'd15);
    check("l2_reload_drop", 64'(i2.drop),   64'd0);
    i2.vldin = 0;
    step();
    check("l2_reload_end", 64'(i2.vldout), 64'd0);

    // LEN=1: every product completes
    i1.rdyout = 1;
    i1.vldin = 1;
    i1.din = 32'd9; step();
    check("l1_vld",  64'(i1.vldout), 64'd1);
    check("l1_dout", 64'(i1.dout),   64'd9);
    check("l1_cnt",  64'(i1.cnt),    64'd0);
    i1.din = 32'd11; step();
    check("l1_dout2", 64'(i1.dout), 64'd11);
    check("l1_drop",  64'(i1.drop), 64'd0);
    i1.vldin = 0;
    step();
    check("l1_end", 64'(i1.vldout), 64'd0);

    // LEN=4 clear: alone, then together with a product
    i4.rdyout = 1;
    i4.vldin = 1;
    i4.din = 32'd1; step();
    i4.din = 32'd2; step();
    i4.vldin = 0;
    i4.clear = 1;
    step();
    check("clr_cnt0", 64'(i4.cnt), 64'd0);
    i4.clear = 0;
    i4.vldin = 1;
    i4.din = 32'd1; step();
    i4.din = 32'd2; step();
    i4.din = 32'd3; step();
    check("clr_cnt3", 64'(i4.cnt), 64'd3);
    i4.clear = 1;
    i4.din = 32'd7;
    step();
    check("clr_vin_cnt", 64'(i4.cnt),    64'd1);
    check("clr_vin_vld", 64'(i4.vldout), 64'd0);
    i4.clear = 0;
    i4.din = 32'd1;
    step();
    step();
    i4.rdyout = 0;
    step();
    check("clr_vld",  64'(i4.vldout), 64'd1);
    check("clr_dout", 64'(i4.dout),   64'd10);

    // Reset mid-sum with an output held
    step();
    step();
    check("mid_cnt2", 64'(i4.cnt), 64'd2);
    i4.vldin = 0;
    rst_n = 1'b0;
    step();
    check("mid_rst_vld",  64'(i4.vldout), 64'd0);
    check("mid_rst_dout", 64'(i4.dout),   64'd0);
    check("mid_rst_cnt",  64'(i4.cnt),    64'd0);
    check("mid_rst_drop", 64'(i4.drop),   64'd0);
    check("mid_rst_sat",  64'(i4.sat),    64'd0);
    rst_n = 1'b1;
    i4.rdyout = 1;
    i4.vldin = 1;
    i4.din = 32'd1;
    for (int k = 0; k < 4; k++) step();
    check("post_rst_dout", 64'(i4.dout),   64'd4);
    check("post_rst_vld",  64'(i4.vldout), 64'd1);
    i4.vldin = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_accum.md
# mul_accum

Downstream consumer of the 16x16 multiplier stage: takes its 32-bit product stream (`vldin`/`din`, one product per valid cycle, no backpressure) and accumulates every LEN consecutive products into one unsigned ACCW-bit sum. Each finished sum is held in an output register and handed to the next stage with a valid/ready handshake. A sticky flag records any sum that had to be dropped because the previous one was still waiting.

## Interface
Parameters:
- DW, 32, product width (matches multiplier `dout`)
- ACCW, 40, accumulator/sum width; ACCW >= DW
- LEN, 16, products per sum; legal range 1..256

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous and active-low (single clock)
- vldin  in  1  product valid, driven by the multiplier `vldout`
- din  in  DW  product, driven by the multiplier `dout`
- clear  in  1  synchronous restart of the current accumulation
- vldout  out  1  `dout` holds a finished sum
- rdyout  in  1  downstream accepts `dout` this cycle
- dout  out  ACCW  finished sum
- sat  out  1  finished sum was clamped (tied 0 when saturation is compiled out)
- drop  out  1  sticky: at least one finished sum was lost
- cnt  out  8  number of products in the current partial sum

## Operation
- All arithmetic is unsigned. `din` is zero-extended to ACCW.
- Accumulator states:
  - EMPTY (cnt==0): on `vldin`, acc<=din, cnt<=1.
  - ACCUM (cnt>0): on `vldin`, acc<=acc+din, cnt<=cnt+1.
- Completion: a `vldin` arriving while cnt==LEN-1 completes the sum (this includes LEN==1, every product).
  - The final sum (acc+din, or din when LEN==1) goes to the output stage.
  - cnt returns to 0 and the accumulator goes to EMPTY in the same cycle.
- Output stage states:
  - OUT_IDLE: a completed sum loads `dout`; go to OUT_FULL and set vldout=1.
  - OUT_FULL: on vldout&&rdyout, go to OUT_IDLE, unless a completion happens in that same cycle; then load the new sum and stay in OUT_FULL.
  - OUT_FULL with a completion and !rdyout: the new sum is discarded, `drop`<=1, and the old `dout` stays unchanged.
- `dout` and `sat` are stable while vldout=1 and rdyout=0.
- `clear`:
  - Forces cnt and acc to EMPTY.
  - Does not touch the output stage or `drop`.
  - clear together with vldin: the product starts a new sum (acc=din, cnt=1).
- `drop` is cleared only by reset.
- Reset values: vldout=0, dout=0, sat=0, drop=0, cnt=0, acc=0, states EMPTY/OUT_IDLE.
- Reset mid-accumulation discards the partial sum and any held output.

## Timing
- A product is accepted in the cycle `vldin` is sampled high. Every cycle can carry a product, so there are no bubbles.
- The final product accepted at edge t appears as vldout=1 with `dout` valid after edge t (registered), i.e. visible in cycle t+1.
- The handshake completes on any edge where vldout&&rdyout. vldout falls after that edge unless it was reloaded.
- `cnt` is registered and reflects products accepted up to the previous edge.

## Configuration
- MUL_ACCUM_SAT_EN defined:
  - Each addition clamps to 2^ACCW-1 when it would carry out of ACCW bits.
  - Once clamped, the sum stays clamped for the rest of that sum.
  - `sat` is registered alongside `dout` and is 1 for a clamped sum.
- Not defined:
  - Sums wrap modulo 2^ACCW.
  - `sat` is constant 0.
  - No compare logic is generated.

## Structure
- Package mul_accum_pkg holds:
  - default DW/ACCW/LEN constants
  - the accumulator state typedef (EMPTY, ACCUM)
  - the output state typedef (OUT_IDLE, OUT_FULL)
- Sub-module mul_accum_hold is the output register plus the valid/ready/drop logic, with ports: load, sum, sat_in, rdyout, vldout, dout, sat, drop.
- The accumulator, counter and clear logic stay in the top level.

## Test plan
- LEN=4, products 100,200,300,400 on consecutive cycles, rdyout=1 → one cycle after the 4th, vldout=1 and dout=1000 for exactly one cycle; cnt returns to 0.
- LEN=256, din=0xFFFFFFFF every cycle, ACCW=40 → dout=0xFF_FFFF_FF00, sat=0.
- ACCW=36, LEN=32, din=0xFFFFFFFF:
  - with MUL_ACCUM_SAT_EN → dout=0xF_FFFF_FFFF, sat=1
  - without it → dout=0xF_FFFF_FFE0, sat=0
- LEN=2, rdyout=0, products 1,2,3,4 → dout holds 3 with vldout=1, drop=1; then rdyout=1 → dout=3 accepted, vldout=0.
- LEN=2, rdyout=1 on the same edge that the next sum completes → vldout stays 1 and dout moves from the first sum to the second; drop=0.
- LEN=4: 3 products, then clear with vldin (din=7), then 3 more products of 1 → dout=10. Separately, rst_n low mid-sum → all outputs return to their reset values on the next edge.
